// File: rtl/ac_cal_pkg.sv
// Shared types and constants for the antenna-calibration sequence scheduler.
package ac_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OFFSET,
    SLOT,
    GAP,
    DONE
  } ac_state_e;

  localparam logic [3:0] AC_RX_GROUP = 4'd8;
  localparam int         AC_SLOT_W   = 7;
  localparam int         AC_ANT_NUM  = 4;
  // The antenna index is 3 bits wide, so no more than 8 antennas can be addressed.
  localparam int         AC_ANT_MAX  = 8;

  // Lowest set bit of an enable mask. Returns 0 for an empty mask, which the
  // caller never accepts anyway.
  function automatic logic [2:0] ac_first_ant(input logic [AC_ANT_MAX-1:0] mask);
    ac_first_ant = 3'd0;
    for (int i = AC_ANT_MAX - 1; i >= 0; i--) begin
      if (mask[i]) ac_first_ant = 3'(i);
    end
  endfunction

endpackage

// File: rtl/ac_ant_pick.sv
// Combinational finder for the next enabled antenna above the current one.
module ac_ant_pick
  import ac_cal_pkg::*;
#(
  parameter int ANT_NUM = AC_ANT_NUM
) (
  input  logic [ANT_NUM-1:0] ant_en,
  input  logic [2:0]         cur_ant,
  output logic [2:0]         next_ant,
  output logic               last
);

  // Enabled antennas strictly above the current one.
  logic [ANT_NUM-1:0] above;

  genvar gi;
  generate
    for (gi = 0; gi < ANT_NUM; gi++) begin : g_above
      assign above[gi] = ant_en[gi] && (3'(gi) > cur_ant);
    end
  endgenerate

  // Priority-select the lowest candidate; no candidate means this is the last slot.
  always_comb begin
    next_ant = cur_ant;
    last     = 1'b1;
    for (int i = ANT_NUM - 1; i >= 0; i--) begin
      if (above[i]) begin
        next_ant = 3'(i);
        last     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ac_seq_ctrl.sv
// Calibration-sequence scheduler: walks enabled antennas and opens one
// insertion slot per antenna, with all outputs registered.
module ac_seq_ctrl
  import ac_cal_pkg::*;
#(
  parameter int ANT_NUM = AC_ANT_NUM,
  parameter int OFS_W   = 16
) (
  input  logic                 clk_245p76,
  input  logic                 asy_rst,
  input  logic                 cal_req,
  input  logic                 reg_cal_dir,
  input  logic [ANT_NUM-1:0]   reg_cal_ant_en,
  input  logic                 reg_seq_insert_en,
  input  logic [OFS_W-1:0]     reg_start_ofs,
  input  logic [AC_SLOT_W-1:0] reg_slot_len,
  input  logic [AC_SLOT_W-1:0] reg_gap_len,
  output logic                 busy,
  output logic                 cal_done,
  output logic                 cfg_err,
  output logic                 tx_ac_valid,
  output logic                 tx_seq_valid,
  output logic                 rx_seq_valid,
  output logic [2:0]           tx_ant_cnt,
  output logic [2:0]           rx_ant_cnt,
  output logic [3:0]           group_index,
  output logic [AC_SLOT_W-1:0] seq_cnt,
  output logic                 seq_insert_en
);

  ac_state_e state_reg, state_next;

  logic [OFS_W-1:0]     ofs_cnt_reg, ofs_cnt_next;
  logic [AC_SLOT_W-1:0] seq_reg, seq_next;
  logic [AC_SLOT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [2:0]           ant_reg, ant_next;
  logic [2:0]           grp_reg, grp_next;
  logic                 pend_reg, pend_next;
  logic                 err_next;

  // Configuration captured at acceptance; the run never looks at reg_* again.
  logic                 sh_dir_reg, sh_dir_next;
  logic [ANT_NUM-1:0]   sh_ant_en_reg, sh_ant_en_next;
  logic                 sh_ins_reg, sh_ins_next;
  logic [OFS_W-1:0]     sh_ofs_reg, sh_ofs_next;
  logic [AC_SLOT_W-1:0] sh_slot_reg, sh_slot_next;
  logic [AC_SLOT_W-1:0] sh_gap_reg, sh_gap_next;

  logic [AC_ANT_MAX-1:0] ant_en_ext;
  logic [2:0]            pick_next;
  logic                  pick_last;
  logic                  req_bad;

  logic                 busy_next, cal_done_next, tx_ac_valid_next;
  logic                 tx_seq_valid_next, rx_seq_valid_next, seq_insert_en_next;
  logic [2:0]           tx_ant_cnt_next, rx_ant_cnt_next;
  logic [3:0]           group_index_next;
  logic [AC_SLOT_W-1:0] seq_cnt_next;

  ac_ant_pick #(.ANT_NUM(ANT_NUM)) u_ant_pick (
    .ant_en   (sh_ant_en_reg),
    .cur_ant  (ant_reg),
    .next_ant (pick_next),
    .last     (pick_last)
  );

  assign req_bad = (reg_slot_len == '0) || (reg_cal_ant_en == '0);

  // Widen the live enable mask so the package helper can search it.
  always_comb begin
    ant_en_ext                = '0;
    ant_en_ext[ANT_NUM-1:0]   = reg_cal_ant_en;
  end

  // Next-state, counters, shadow capture and the single pending-request bit.
  always_comb begin
    state_next     = state_reg;
    ofs_cnt_next   = ofs_cnt_reg;
    seq_next       = seq_reg;
    gap_cnt_next   = gap_cnt_reg;
    ant_next       = ant_reg;
    grp_next       = grp_reg;
    pend_next      = pend_reg;
    err_next       = cfg_err;
    sh_dir_next    = sh_dir_reg;
    sh_ant_en_next = sh_ant_en_reg;
    sh_ins_next    = sh_ins_reg;
    sh_ofs_next    = sh_ofs_reg;
    sh_slot_next   = sh_slot_reg;
    sh_gap_next    = sh_gap_reg;

    if (state_reg != IDLE && cal_req) pend_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (cal_req || pend_reg) begin
          pend_next = 1'b0;
          if (req_bad) begin
            err_next = 1'b1;
          end else begin
            sh_dir_next    = reg_cal_dir;
            sh_ant_en_next = reg_cal_ant_en;
            sh_ins_next    = reg_seq_insert_en;
            sh_ofs_next    = reg_start_ofs;
            sh_slot_next   = reg_slot_len;
            sh_gap_next    = reg_gap_len;
            ant_next       = ac_first_ant(ant_en_ext);
            ofs_cnt_next   = OFS_W'(1);
            state_next     = OFFSET;
          end
        end
      end
      OFFSET: begin
        // Counter starts at 1 so a zero offset still spends one cycle here.
        if (ofs_cnt_reg >= sh_ofs_reg) begin
          state_next = SLOT;
          seq_next   = '0;
        end else begin
          ofs_cnt_next = ofs_cnt_reg + OFS_W'(1);
        end
      end
      SLOT: begin
        if (seq_reg == sh_slot_reg - 7'd1) begin
          if (pick_last) begin
            state_next = DONE;
          end else begin
            ant_next = pick_next;
            seq_next = '0;
            if (sh_gap_reg != '0) begin
              state_next   = GAP;
              gap_cnt_next = 7'd1;
            end
          end
        end else begin
          seq_next = seq_reg + 7'd1;
        end
      end
      GAP: begin
        if (gap_cnt_reg >= sh_gap_reg) begin
          state_next = SLOT;
          seq_next   = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 7'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (sh_dir_reg) grp_next = grp_reg + 3'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    busy_next          = (state_next != IDLE);
    cal_done_next      = (state_next == DONE);
    tx_ac_valid_next   = busy_next && sh_dir_next;
    tx_seq_valid_next  = (state_next == SLOT) && sh_dir_next;
    rx_seq_valid_next  = (state_next == SLOT) && !sh_dir_next;
    seq_insert_en_next = (state_next == SLOT) && sh_dir_next && sh_ins_next;
    seq_cnt_next       = (state_next == SLOT) ? seq_next : '0;
    tx_ant_cnt_next    = (busy_next && sh_dir_next) ? ant_next : 3'd0;
    rx_ant_cnt_next    = (busy_next && !sh_dir_next) ? ant_next : 3'd0;
    group_index_next   = (busy_next && !sh_dir_next) ? AC_RX_GROUP : {1'b0, grp_next};
  end

  // Control state and shadow registers.
  always_ff @(posedge clk_245p76 or negedge asy_rst) begin
    if (!asy_rst) begin
      state_reg     <= IDLE;
      ofs_cnt_reg   <= '0;
      seq_reg       <= '0;
      gap_cnt_reg   <= '0;
      ant_reg       <= '0;
      grp_reg       <= '0;
      pend_reg      <= 1'b0;
      sh_dir_reg    <= 1'b0;
      sh_ant_en_reg <= '0;
      sh_ins_reg    <= 1'b0;
      sh_ofs_reg    <= '0;
      sh_slot_reg   <= '0;
      sh_gap_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ofs_cnt_reg   <= ofs_cnt_next;
      seq_reg       <= seq_next;
      gap_cnt_reg   <= gap_cnt_next;
      ant_reg       <= ant_next;
      grp_reg       <= grp_next;
      pend_reg      <= pend_next;
      sh_dir_reg    <= sh_dir_next;
      sh_ant_en_reg <= sh_ant_en_next;
      sh_ins_reg    <= sh_ins_next;
      sh_ofs_reg    <= sh_ofs_next;
      sh_slot_reg   <= sh_slot_next;
      sh_gap_reg    <= sh_gap_next;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_245p76 or negedge asy_rst) begin
    if (!asy_rst) begin
      busy          <= 1'b0;
      cal_done      <= 1'b0;
      cfg_err       <= 1'b0;
      tx_ac_valid   <= 1'b0;
      tx_seq_valid  <= 1'b0;
      rx_seq_valid  <= 1'b0;
      tx_ant_cnt    <= '0;
      rx_ant_cnt    <= '0;
      group_index   <= '0;
      seq_cnt       <= '0;
      seq_insert_en <= 1'b0;
    end else begin
      busy          <= busy_next;
      cal_done      <= cal_done_next;
      cfg_err       <= err_next;
      tx_ac_valid   <= tx_ac_valid_next;
      tx_seq_valid  <= tx_seq_valid_next;
      rx_seq_valid  <= rx_seq_valid_next;
      tx_ant_cnt    <= tx_ant_cnt_next;
      rx_ant_cnt    <= rx_ant_cnt_next;
      group_index   <= group_index_next;
      seq_cnt       <= seq_cnt_next;
      seq_insert_en <= seq_insert_en_next;
    end
  end

endmodule

// File: tb/tb_ac_seq_ctrl.sv
// Self-checking bench for ac_seq_ctrl: schedule-based reference model checked
// every cycle, a table of directed runs, hand-written corner sequences and
// randomized traffic.
module tb_ac_seq_ctrl;

  logic        clk_245p76 = 1'b0;
  logic        asy_rst = 1'b0;
  logic        cal_req = 1'b0;
  logic        reg_cal_dir = 1'b0;
  logic [3:0]  reg_cal_ant_en = '0;
  logic        reg_seq_insert_en = 1'b0;
  logic [15:0] reg_start_ofs = '0;
  logic [6:0]  reg_slot_len = '0;
  logic [6:0]  reg_gap_len = '0;
  logic        busy, cal_done, cfg_err, tx_ac_valid, tx_seq_valid, rx_seq_valid;
  logic [2:0]  tx_ant_cnt, rx_ant_cnt;
  logic [3:0]  group_index;
  logic [6:0]  seq_cnt;
  logic        seq_insert_en;

  int checks = 0;
  int errors = 0;

  ac_seq_ctrl #(.ANT_NUM(4), .OFS_W(16)) dut (
    .clk_245p76        (clk_245p76),
    .asy_rst           (asy_rst),
    .cal_req           (cal_req),
    .reg_cal_dir       (reg_cal_dir),
    .reg_cal_ant_en    (reg_cal_ant_en),
    .reg_seq_insert_en (reg_seq_insert_en),
    .reg_start_ofs     (reg_start_ofs),
    .reg_slot_len      (reg_slot_len),
    .reg_gap_len       (reg_gap_len),
    .busy              (busy),
    .cal_done          (cal_done),
    .cfg_err           (cfg_err),
    .tx_ac_valid       (tx_ac_valid),
    .tx_seq_valid      (tx_seq_valid),
    .rx_seq_valid      (rx_seq_valid),
    .tx_ant_cnt        (tx_ant_cnt),
    .rx_ant_cnt        (rx_ant_cnt),
    .group_index       (group_index),
    .seq_cnt           (seq_cnt),
    .seq_insert_en     (seq_insert_en)
  );

  always #2 clk_245p76 = ~clk_245p76;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-cycle expected output schedule ----------------
  typedef struct {
    int busy; int done; int tx_ac; int txv; int rxv;
    int txa; int rxa; int grp; int seq; int ins;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_grp;
  bit   m_pend;
  bit   m_err;

  function automatic exp_t idle_rec(input int g);
    exp_t r;
    r = '{default: 0};
    r.grp = g;
    return r;
  endfunction

  // Expand one accepted run into its full cycle-by-cycle output list.
  function automatic void build(input bit dir, input logic [3:0] en, input bit ins,
                                input int ofs, input int slot, input int gap);
    int   ants[$];
    exp_t r, s;
    for (int a = 0; a < 4; a++) if (en[a]) ants.push_back(a);
    r = idle_rec(dir ? m_grp : 8);
    r.busy = 1; r.tx_ac = dir;
    r.txa = dir ? ants[0] : 0; r.rxa = dir ? 0 : ants[0];
    for (int i = 0; i < ((ofs == 0) ? 1 : ofs); i++) q.push_back(r);
    for (int k = 0; k < ants.size(); k++) begin
      for (int n = 0; n < slot; n++) begin
        s = r; s.txv = dir; s.rxv = !dir; s.seq = n; s.ins = dir && ins;
        q.push_back(s);
      end
      if (k < ants.size() - 1) begin
        r.txa = dir ? ants[k+1] : 0; r.rxa = dir ? 0 : ants[k+1];
        for (int g = 0; g < gap; g++) q.push_back(r);
      end
    end
    r.done = 1;
    q.push_back(r);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_grp = 0; m_pend = 0; m_err = 0;
    cur = idle_rec(0);
  endfunction

  function automatic void model_step();
    if (cur.done != 0 && cur.tx_ac != 0) m_grp = (m_grp + 1) % 8;
    if (cur.busy != 0) begin
      if (cal_req) m_pend = 1;
    end else if (cal_req || m_pend) begin
      m_pend = 0;
      if (reg_slot_len == 0 || reg_cal_ant_en == 0) m_err = 1;
      else build(reg_cal_dir, reg_cal_ant_en, reg_seq_insert_en,
                 int'(reg_start_ofs), int'(reg_slot_len), int'(reg_gap_len));
    end
    if (q.size() > 0) cur = q.pop_front();
    else cur = idle_rec(m_grp);
  endfunction

  // Monitor: advance the model on every edge, compare #1 later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk_245p76);
      if (!asy_rst) model_reset();
      else model_step();
      #1;
      if (asy_rst) begin
        chk("mon_busy", busy, cur.busy);
        chk("mon_cal_done", cal_done, cur.done);
        chk("mon_tx_ac_valid", tx_ac_valid, cur.tx_ac);
        chk("mon_tx_seq_valid", tx_seq_valid, cur.txv);
        chk("mon_rx_seq_valid", rx_seq_valid, cur.rxv);
        chk("mon_tx_ant_cnt", tx_ant_cnt, cur.txa);
        chk("mon_rx_ant_cnt", rx_ant_cnt, cur.rxa);
        chk("mon_group_index", group_index, cur.grp);
        chk("mon_seq_cnt", seq_cnt, cur.seq);
        chk("mon_seq_insert_en", seq_insert_en, cur.ins);
        chk("mon_cfg_err", cfg_err, m_err);
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit dir; logic [3:0] en; bit ins; int ofs; int slot; int gap;
    int exp_busy; int exp_valid; int exp_done; int exp_lat; int exp_code; int exp_err; int exp_grp;
  } vec_t;

  vec_t tbl[7];

  task automatic set_regs(input bit dir, input logic [3:0] en, input bit ins,
                          input int ofs, input int slot, input int gap);
    reg_cal_dir = dir; reg_cal_ant_en = en; reg_seq_insert_en = ins;
    reg_start_ofs = 16'(ofs); reg_slot_len = 7'(slot); reg_gap_len = 7'(gap);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int cyc = 0, busy_n = 0, valid_n = 0, done_n = 0, lat = 0, code = 0;
    @(negedge clk_245p76);
    set_regs(v.dir, v.en, v.ins, v.ofs, v.slot, v.gap);
    cal_req = 1'b1;
    do begin
      @(posedge clk_245p76); #1;
      cyc++;
      if (cyc == 1) cal_req = 1'b0;
      if (busy) busy_n++;
      if (cal_done) done_n++;
      if (tx_seq_valid || rx_seq_valid) begin
        valid_n++;
        if (lat == 0) lat = cyc;
        if (seq_cnt == 0) code = code * 8 + int'(tx_ant_cnt) + int'(rx_ant_cnt) + 1;
      end
    end while ((cyc < 2 || busy) && cyc < 300);
    if (cyc >= 300) chk($sformatf("row%0d_timeout", idx), 1, 0);
    chk($sformatf("row%0d_busy_cycles", idx), busy_n, v.exp_busy);
    chk($sformatf("row%0d_valid_cycles", idx), valid_n, v.exp_valid);
    chk($sformatf("row%0d_done_pulses", idx), done_n, v.exp_done);
    chk($sformatf("row%0d_first_valid", idx), lat, v.exp_lat);
    chk($sformatf("row%0d_ant_order", idx), code, v.exp_code);
    chk($sformatf("row%0d_cfg_err", idx), cfg_err, v.exp_err);
    chk($sformatf("row%0d_group", idx), group_index, v.exp_grp);
  endtask

  initial begin
    int cyc, done_n, d1, d2, rxv_n, txv_n, rx_ant;
    logic busy_hist[64];

    //            dir en       ins ofs slot gap  busy valid done lat code err grp
    tbl[0] = '{1, 4'b1011, 1,  3,  8,   2,   32,  24,   1,   4,  84,  0,  1};
    tbl[1] = '{0, 4'b0001, 1,  0,  16,  5,   18,  16,   1,   2,  1,   0,  1};
    tbl[2] = '{1, 4'b1111, 0,  0,  1,   0,   6,   4,    1,   2,  668, 0,  2};
    tbl[3] = '{1, 4'b0100, 1,  1,  3,   7,   5,   3,    1,   2,  3,   0,  3};
    tbl[4] = '{0, 4'b1010, 0,  2,  2,   1,   8,   4,    1,   3,  20,  0,  3};
    tbl[5] = '{1, 4'b1111, 1,  2,  0,   1,   0,   0,    0,   0,  0,   1,  3};
    tbl[6] = '{1, 4'b0000, 1,  0,  5,   0,   0,   0,    0,   0,  0,   1,  3};

    // Reset state
    @(posedge clk_245p76); #1;
    chk("reset_state", 32'({busy, cal_done, cfg_err, tx_ac_valid, tx_seq_valid, rx_seq_valid,
                            tx_ant_cnt, rx_ant_cnt, group_index, seq_cnt, seq_insert_en}), 0);
    @(negedge clk_245p76);
    asy_rst = 1'b1;

    foreach (tbl[i]) run_row(i, tbl[i]);

    // Collision: two requests mid-run plus a register rewrite; exactly one
    // extra run, using the rewritten values, starting two cycles after DONE.
    @(negedge clk_245p76);
    set_regs(1, 4'b0011, 1, 2, 4, 1);
    cal_req = 1'b1;
    cyc = 0; done_n = 0; d1 = 0; d2 = 0; rxv_n = 0; txv_n = 0; rx_ant = -1;
    while (cyc < 40) begin
      @(posedge clk_245p76); #1;
      cyc++;
      cal_req = (cyc == 3 || cyc == 5);
      if (cyc == 3) set_regs(0, 4'b0100, 1, 0, 2, 0);
      busy_hist[cyc] = busy;
      if (tx_seq_valid) txv_n++;
      if (rx_seq_valid) begin rxv_n++; rx_ant = int'(rx_ant_cnt); end
      if (cal_done) begin
        done_n++;
        if (d1 == 0) d1 = cyc; else d2 = cyc;
      end
    end
    chk("coll_done_pulses", done_n, 2);
    chk("coll_first_done", d1, 12);
    chk("coll_second_done", d2, 17);
    chk("coll_idle_after_done", busy_hist[13], 0);
    chk("coll_restart_busy", busy_hist[14], 1);
    chk("coll_old_tx_valid", txv_n, 8);
    chk("coll_new_rx_valid", rxv_n, 2);
    chk("coll_new_rx_ant", rx_ant, 2);

    // Reset during the slot of antenna 1.
    @(negedge clk_245p76);
    set_regs(1, 4'b0011, 1, 0, 4, 0);
    cal_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_245p76); #1;
      cal_req = 1'b0;
    end
    chk("pre_rst_ant", tx_ant_cnt, 1);
    chk("pre_rst_valid", tx_seq_valid, 1);
    #1 asy_rst = 1'b0;
    #1;
    chk("rst_outputs", 32'({busy, cal_done, cfg_err, tx_ac_valid, tx_seq_valid, rx_seq_valid,
                            tx_ant_cnt, rx_ant_cnt, seq_cnt, seq_insert_en}), 0);
    chk("rst_group", group_index, 0);
    @(negedge clk_245p76);
    @(negedge clk_245p76);
    asy_rst = 1'b1;
    @(negedge clk_245p76);
    set_regs(1, 4'b0110, 1, 0, 2, 0);
    cal_req = 1'b1;
    @(posedge clk_245p76); #1;
    cal_req = 1'b0;
    chk("restart_ant", tx_ant_cnt, 1);
    chk("restart_group", group_index, 0);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk_245p76); #1;
      cyc++;
    end
    chk("restart_finished", busy, 0);
    chk("restart_group_after", group_index, 1);

    // Randomized traffic, including illegal configs and mid-run rewrites.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk_245p76);
      cal_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        set_regs(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 2));
    end
    @(negedge clk_245p76);
    cal_req = 1'b0;
    repeat (100) @(negedge clk_245p76);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
